// File: rtl/matrix_readout.sv
// Read-side sequencer for matrix_storage: validates a (m,n,slot) request, then
// walks the matrix row-major, one rd_en strobe per element, streaming to a sink.
module matrix_readout #(
    parameter int MAX_DIM    = 5,
    parameter int ELEM_WIDTH = 8,
    parameter int DIM_BITS   = 3,
    parameter int TIMEOUT    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [3:0]            m,
    input  logic [3:0]            n,
    input  logic                  slot_idx,
    input  logic                  abort,
    output logic [3:0]            query_m,
    output logic [3:0]            query_n,
    input  logic                  query_slot0_valid,
    input  logic                  query_slot1_valid,
    output logic                  rd_en,
    output logic [3:0]            rd_m,
    output logic [3:0]            rd_n,
    output logic                  rd_slot_idx,
    output logic [DIM_BITS-1:0]   rd_row_idx,
    output logic [DIM_BITS-1:0]   rd_col_idx,
    input  logic [ELEM_WIDTH-1:0] rd_elem,
    input  logic                  rd_elem_valid,
    output logic [ELEM_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_eol,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [1:0]            err_code
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_REQ, S_WAIT, S_OUT} state_t;

    state_t                r_state, w_next;
    logic [3:0]            r_m, r_n;
    logic                  r_slot;
    logic [DIM_BITS-1:0]   r_row, r_col;
    logic [TMO_W-1:0]      r_tmo;
    logic [ELEM_WIDTH-1:0] r_data;
    logic                  r_done, r_err;
    logic [1:0]            r_err_code;

    logic       w_dims_ok, w_slot_ok, w_hs, w_eol, w_last, w_accept;
    logic       w_set_err;
    logic [1:0] w_code;

    assign w_dims_ok = (m >= 4'd1) && (m <= 4'(MAX_DIM)) && (n >= 4'd1) && (n <= 4'(MAX_DIM));
    assign w_slot_ok = r_slot ? query_slot1_valid : query_slot0_valid;
    assign w_hs      = (r_state == S_OUT) && out_ready;
    assign w_eol     = (4'(r_col) == r_n - 4'd1);
    assign w_last    = w_eol && (4'(r_row) == r_m - 4'd1);
    assign w_accept  = (r_state == S_IDLE) && start && !abort;

    always_comb begin
        w_next    = r_state;
        w_set_err = 1'b0;
        w_code    = 2'b00;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (w_dims_ok) begin
                        w_next = S_CHECK;
                    end else begin
                        w_set_err = 1'b1;
                        w_code    = 2'b01;
                    end
                end
            end
            S_CHECK: begin
                if (w_slot_ok) begin
                    w_next = S_REQ;
                end else begin
                    w_next    = S_IDLE;
                    w_set_err = 1'b1;
                    w_code    = 2'b10;
                end
            end
            S_REQ:  w_next = S_WAIT;
            S_WAIT: begin
                if (rd_elem_valid) begin
                    w_next = S_OUT;
                end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
                    w_next    = S_IDLE;
                    w_set_err = 1'b1;
                    w_code    = 2'b11;
                end
            end
            S_OUT: begin
                if (out_ready) w_next = w_last ? S_IDLE : S_REQ;
            end
            default: w_next = S_IDLE;
        endcase
        // abort overrides everything, including errors detected this cycle
        if (abort) begin
            w_next    = S_IDLE;
            w_set_err = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_m        <= '0;
            r_n        <= '0;
            r_slot     <= 1'b0;
            r_row      <= '0;
            r_col      <= '0;
            r_tmo      <= '0;
            r_data     <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= 2'b00;
        end else begin
            r_state <= w_next;
            r_done  <= w_hs && w_last && !abort;
            r_err   <= w_set_err;
            r_tmo   <= (r_state == S_WAIT) ? r_tmo + TMO_W'(1) : '0;
            if (w_set_err)     r_err_code <= w_code;
            else if (w_accept) r_err_code <= 2'b00;
            if (w_accept) begin
                r_m    <= m;
                r_n    <= n;
                r_slot <= slot_idx;
                r_row  <= '0;
                r_col  <= '0;
            end
            if (r_state == S_WAIT && rd_elem_valid) r_data <= rd_elem;
            if (w_hs && !w_last) begin
                if (w_eol) begin
                    r_col <= '0;
                    r_row <= r_row + DIM_BITS'(1);
                end else begin
                    r_col <= r_col + DIM_BITS'(1);
                end
            end
        end
    end

    assign busy        = (r_state != S_IDLE);
    assign rd_en       = (r_state == S_REQ);
    assign out_valid   = (r_state == S_OUT);
    assign out_eol     = out_valid && w_eol;
    assign out_last    = out_valid && w_last;
    assign out_data    = r_data;
    assign done        = r_done;
    assign err         = r_err;
    assign err_code    = r_err_code;
    assign query_m     = busy ? r_m : 4'd0;
    assign query_n     = busy ? r_n : 4'd0;
    assign rd_m        = busy ? r_m : 4'd0;
    assign rd_n        = busy ? r_n : 4'd0;
    assign rd_slot_idx = busy && r_slot;
    assign rd_row_idx  = busy ? r_row : '0;
    assign rd_col_idx  = busy ? r_col : '0;
endmodule

// File: tb/tb_matrix_readout.sv
// Scoreboard bench for matrix_readout with a registered storage stub.
module tb_matrix_readout;
    logic       clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, slot_idx = 1'b0;
    logic [3:0] m = 4'd0, n = 4'd0;
    logic       q0v = 1'b1, q1v = 1'b1, rd_elem_valid = 1'b0, out_ready = 1'b1;
    logic [7:0] rd_elem = 8'd0;
    logic [3:0] query_m, query_n, rd_m, rd_n;
    logic       rd_en, rd_slot_idx, out_valid, out_eol, out_last, busy, done, err;
    logic [2:0] rd_row_idx, rd_col_idx;
    logic [7:0] out_data;
    logic [1:0] err_code;

    matrix_readout dut (
        .clk(clk), .rst_n(rst_n), .start(start), .m(m), .n(n), .slot_idx(slot_idx),
        .abort(abort), .query_m(query_m), .query_n(query_n),
        .query_slot0_valid(q0v), .query_slot1_valid(q1v),
        .rd_en(rd_en), .rd_m(rd_m), .rd_n(rd_n), .rd_slot_idx(rd_slot_idx),
        .rd_row_idx(rd_row_idx), .rd_col_idx(rd_col_idx),
        .rd_elem(rd_elem), .rd_elem_valid(rd_elem_valid),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_eol(out_eol), .out_last(out_last),
        .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    // storage stub: one-cycle read latency, responds to rd_en rising edges only
    logic [7:0] mem [0:1][0:24];
    logic       stub_en = 1'b1, rd_en_q = 1'b0;
    always @(posedge clk) begin
        rd_en_q       <= rd_en;
        rd_elem_valid <= stub_en && rd_en && !rd_en_q;
        rd_elem       <= mem[rd_slot_idx][int'(rd_row_idx) * int'(rd_n) + int'(rd_col_idx)];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0, bad = 0;
    logic [9:0] sbq [$];
    int rd_edges, hs_cnt, done_cnt, err_cnt, first_req, last_hs, done_cyc, err_cyc, start_cyc;
    logic busy_seen, rd_prev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        rd_edges = 0; hs_cnt = 0; done_cnt = 0; err_cnt = 0;
        first_req = -1; last_hs = -1; done_cyc = -1; err_cyc = -1; busy_seen = 1'b0;
    endtask

    initial begin
        logic [9:0] e;
        clear_stats();
        forever begin
            @(negedge clk);
            if (rd_en && !rd_prev) begin
                rd_edges++;
                if (first_req < 0) first_req = cyc;
            end
            rd_prev = rd_en;
            if (busy) busy_seen = 1'b1;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (err)  begin err_cnt++;  err_cyc  = cyc; end
            if (out_valid && out_ready) begin
                hs_cnt++;
                last_hs = cyc;
                if (sbq.size() == 0) chk("sb_empty", 32'd1, 32'd0);
                else begin
                    e = sbq.pop_front();
                    chk("sb_elem", {22'd0, out_last, out_eol, out_data}, {22'd0, e});
                end
            end
        end
    end

    task automatic tick(input int k);
        repeat (k) begin @(posedge clk); #1; end
    endtask

    task automatic push_mat(input int r, input int c, input int s);
        for (int k = 0; k < r * c; k++)
            sbq.push_back({(k == r * c - 1), ((k % c) == c - 1), mem[s][k]});
    endtask

    task automatic go(input int r, input int c, input int s);
        m = 4'(r); n = 4'(c); slot_idx = s[0];
        start = 1'b1; start_cyc = cyc;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_end(input int maxc);
        int k = 0;
        while (done_cnt + err_cnt == 0 && k < maxc) begin tick(1); k++; end
        if (k >= maxc) chk("wait_bound", 32'd0, 32'd1);
        tick(2);
    endtask

    task automatic wait_hs(input int target);
        int k = 0;
        while (hs_cnt < target && k < 200) begin tick(1); k++; end
        if (k >= 200) chk("hs_bound", 32'(hs_cnt), 32'(target));
    endtask

    task automatic chk_zero_outs(input string tag);
        chk(tag, {busy, out_valid, rd_en, done, err, err_code, out_eol, out_last, rd_slot_idx,
                  query_m, query_n, rd_m, rd_n, out_data}, 32'd0);
        chk({tag, "_idx"}, {26'd0, rd_row_idx, rd_col_idx}, 32'd0);
    endtask

    initial begin
        int cnt, k;
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 25; i++) mem[s][i] = 8'(s * 8'h40 + i + 1);

        // reset state
        tick(2);
        chk_zero_outs("reset");
        rst_n = 1'b1;
        tick(2);

        // 2x3 streaming with sink always ready
        clear_stats(); push_mat(2, 3, 0); go(2, 3, 0); wait_end(100);
        chk("t1_done", 32'(done_cnt), 32'd1);
        chk("t1_hs", 32'(hs_cnt), 32'd6);
        chk("t1_rd_edges", 32'(rd_edges), 32'd6);
        chk("t1_done_lat", 32'(done_cyc - last_hs), 32'd1);
        chk("t1_span", 32'(last_hs - first_req + 1), 32'd18);

        // same matrix, sink stalls 5 cycles on element 2
        clear_stats(); push_mat(2, 3, 0); go(2, 3, 0);
        wait_hs(1); out_ready = 1'b0;
        cnt = 0; k = 0;
        while (cnt < 5 && k < 50) begin
            if (out_valid) begin chk("t2_hold", 32'(out_data), 32'd2); cnt++; end
            tick(1); k++;
        end
        out_ready = 1'b1;
        wait_end(100);
        chk("t2_done", 32'(done_cnt), 32'd1);
        chk("t2_hs", 32'(hs_cnt), 32'd6);
        chk("t2_rd_edges", 32'(rd_edges), 32'd6);

        // illegal dims
        clear_stats(); go(6, 2, 0); tick(3);
        chk("t3_err", 32'(err_cnt), 32'd1);
        chk("t3_err_lat", 32'(err_cyc - start_cyc), 32'd1);
        chk("t3_code", 32'(err_code), 32'd1);
        chk("t3_busy", 32'(busy_seen), 32'd0);
        chk("t3_rd", 32'(rd_edges), 32'd0);

        // empty slot
        q1v = 1'b0;
        clear_stats(); go(5, 5, 1); tick(4);
        chk("t4_err", 32'(err_cnt), 32'd1);
        chk("t4_err_lat", 32'(err_cyc - start_cyc), 32'd2);
        chk("t4_code", 32'(err_code), 32'd2);
        chk("t4_rd", 32'(rd_edges), 32'd0);
        q1v = 1'b1;

        // storage never answers
        stub_en = 1'b0;
        clear_stats(); go(2, 2, 0); wait_end(30);
        chk("t5_code", 32'(err_code), 32'd3);
        chk("t5_err_lat", 32'(err_cyc - first_req), 32'd5);
        chk("t5_rd", 32'(rd_edges), 32'd1);
        chk("t5_done", 32'(done_cnt), 32'd0);
        stub_en = 1'b1;

        // 1x1 from slot 1: single element flagged eol and last; new start clears err_code
        clear_stats(); push_mat(1, 1, 1); go(1, 1, 1); wait_end(30);
        chk("t6_done", 32'(done_cnt), 32'd1);
        chk("t6_hs", 32'(hs_cnt), 32'd1);
        chk("t6_code", 32'(err_code), 32'd0);

        // abort mid-transfer
        clear_stats(); push_mat(3, 3, 0); go(3, 3, 0);
        wait_hs(1); tick(1);
        abort = 1'b1; tick(1); abort = 1'b0;
        chk("t7_busy", {busy, out_valid}, 32'd0);
        sbq.delete(); tick(4);
        chk("t7_no_end", 32'(done_cnt + err_cnt), 32'd0);

        // reset during element 3 of a 3x3, then a clean rerun with a stray start
        clear_stats(); push_mat(3, 3, 0); go(3, 3, 0);
        wait_hs(2);
        rst_n = 1'b0; #1;
        chk_zero_outs("t8_rst");
        sbq.delete(); tick(2);
        chk_zero_outs("t8_rst_hold");
        rst_n = 1'b1; tick(2);
        chk("t8_no_end", 32'(done_cnt + err_cnt), 32'd0);
        clear_stats(); push_mat(3, 3, 0); go(3, 3, 0);
        wait_hs(3); go(2, 2, 1);
        wait_end(100);
        chk("t8_done", 32'(done_cnt), 32'd1);
        chk("t8_hs", 32'(hs_cnt), 32'd9);
        chk("t8_rd", 32'(rd_edges), 32'd9);
        chk("t8_sb_left", 32'(sbq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
